matrix_op_sequencer: RTL and testbench

MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

---
 rtl/matrix_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_sequencer.sv
// Matrix op sequencer: slot lookup, checks, operand load, ALU start/wait, then commit or error.
// Accept at cycle 0; load at 3; start at 4; commit one cycle after alu_done; cmd_ready stays low until the drain ends.
module matrix_op_sequencer #(
  parameter int TIMEOUT      = 255,
  parameter int DRAIN_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_a_id,
  input  logic [3:0]  cmd_b_id,
  input  logic [29:0] list_m_flat,
  input  logic [29:0] list_n_flat,
  input  logic [9:0]  list_valid_flat,
  output logic        req_list_info,
  output logic        load_operands,
  output logic [3:0]  operand_a_id,
  output logic [3:0]  operand_b_id,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  input  logic        alu_done,
  input  logic [2:0]  alu_res_m,
  input  logic [2:0]  alu_res_n,
  output logic        op_done,
  output logic [2:0]  result_m,
  output logic [2:0]  result_n,
  output logic        busy,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT);
  localparam logic [DW-1:0] D_LAST  = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_TR  = 2'd1;
  localparam logic [1:0] OP_SC  = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_LIST, S_CHECK, S_LOAD, S_START, S_WAIT, S_COMMIT, S_DRAIN, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q;
  logic [3:0]      a_id_q, b_id_q;
  logic [2:0]      exp_m_q, exp_n_q;
  logic [2:0]      res_m_q, res_n_q;
  logic [1:0]      err_code_q, err_d;
  logic [TW-1:0]   tcnt_q;
  logic [DW-1:0]   dcnt_q;

  // Ids above 9 never match a slot, so they read back as invalid with zero dims.
  function automatic logic [2:0] slot_dim(input logic [29:0] flat, input logic [3:0] id);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) begin
      if (id == 4'(k)) r = flat[3*k +: 3];
    end
    return r;
  endfunction

  function automatic logic slot_ok(input logic [9:0] vld, input logic [3:0] id);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (id == 4'(k)) r = vld[k];
    end
    return r;
  endfunction

  logic [2:0] a_m, a_n, b_m, b_n, chk_m, chk_n;
  logic       a_ok, b_ok, need_b, dims_ok, res_ok;

  always_comb begin
    a_m     = slot_dim(list_m_flat, a_id_q);
    a_n     = slot_dim(list_n_flat, a_id_q);
    b_m     = slot_dim(list_m_flat, b_id_q);
    b_n     = slot_dim(list_n_flat, b_id_q);
    a_ok    = slot_ok(list_valid_flat, a_id_q);
    b_ok    = slot_ok(list_valid_flat, b_id_q);
    need_b  = (op_q == OP_ADD) || (op_q == OP_MUL);
    dims_ok = 1'b1;
    chk_m   = a_m;
    chk_n   = a_n;
    case (op_q)
      OP_ADD: dims_ok = (a_m == b_m) && (a_n == b_n);
      OP_TR: begin
        chk_m = a_n;
        chk_n = a_m;
      end
      OP_MUL: begin
        dims_ok = (a_n == b_m);
        chk_n   = b_n;
      end
      default: ;
    endcase
    res_ok = (alu_res_m == exp_m_q) && (alu_res_n == exp_n_q);
  end

  always_comb begin
    state_d = state_q;
    err_d   = 2'd0;
    case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_LIST;
      S_LIST:   state_d = S_CHECK;
      S_CHECK: begin
        if (!a_ok || (need_b && !b_ok)) begin
          state_d = S_ERR;
          err_d   = 2'd1;
        end else if (!dims_ok) begin
          state_d = S_ERR;
          err_d   = 2'd2;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD:   state_d = S_START;
      S_START:  state_d = S_WAIT;
      // A completion in the final allowed cycle beats the timeout.
      S_WAIT: begin
        if (alu_done) begin
          if (res_ok) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_ERR;
            err_d   = 2'd2;
          end
        end else if (tcnt_q == T_LIMIT) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end
      end
      S_COMMIT: state_d = S_DRAIN;
      S_DRAIN:  if (dcnt_q == D_LAST) state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      a_id_q     <= 4'd0;
      b_id_q     <= 4'd0;
      exp_m_q    <= 3'd0;
      exp_n_q    <= 3'd0;
      res_m_q    <= 3'd0;
      res_n_q    <= 3'd0;
      err_code_q <= 2'd0;
      tcnt_q     <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            a_id_q <= cmd_a_id;
            b_id_q <= cmd_b_id;
          end
        end
        S_CHECK: begin
          exp_m_q <= chk_m;
          exp_n_q <= chk_n;
        end
        S_START:  tcnt_q <= '0;
        S_WAIT: begin
          tcnt_q <= tcnt_q + TW'(1);
          if (alu_done && res_ok) begin
            res_m_q <= alu_res_m;
            res_n_q <= alu_res_n;
          end
        end
        S_COMMIT: dcnt_q <= '0;
        S_DRAIN:  dcnt_q <= dcnt_q + DW'(1);
        default: ;
      endcase
      if (state_d == S_ERR) err_code_q <= err_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = ~cmd_ready;
  assign req_list_info = (state_q == S_LIST);
  assign load_operands = (state_q == S_LOAD);
  assign operand_a_id  = a_id_q;
  assign operand_b_id  = (op_q == OP_TR || op_q == OP_SC) ? a_id_q : b_id_q;
  assign alu_start     = (state_q == S_START);
  assign alu_op        = op_q;
  assign op_done       = (state_q == S_COMMIT);
  assign result_m      = res_m_q;
  assign result_n      = res_n_q;
  assign err_valid     = (state_q == S_ERR);
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: directed vector table, reset-abort sequences, randomized ops vs a timeline model.
module tb_matrix_op_sequencer;
  localparam int TO = 10;
  localparam int DR = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_a_id = '0, cmd_b_id = '0;
  logic [29:0] list_m_flat = '0, list_n_flat = '0;
  logic [9:0]  list_valid_flat = '0;
  logic        req_list_info, load_operands, alu_start, op_done, busy, err_valid;
  logic [3:0]  operand_a_id, operand_b_id;
  logic [1:0]  alu_op, err_code;
  logic        alu_done = 1'b0;
  logic [2:0]  alu_res_m = '0, alu_res_n = '0;
  logic [2:0]  result_m, result_n;

  matrix_op_sequencer #(.TIMEOUT(TO), .DRAIN_CYCLES(DR)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a_id(cmd_a_id), .cmd_b_id(cmd_b_id),
    .list_m_flat(list_m_flat), .list_n_flat(list_n_flat), .list_valid_flat(list_valid_flat),
    .req_list_info(req_list_info), .load_operands(load_operands),
    .operand_a_id(operand_a_id), .operand_b_id(operand_b_id),
    .alu_start(alu_start), .alu_op(alu_op),
    .alu_done(alu_done), .alu_res_m(alu_res_m), .alu_res_n(alu_res_n),
    .op_done(op_done), .result_m(result_m), .result_n(result_n),
    .busy(busy), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {int code; int ecyc; int em; int en; bit loads;} pred_t;
  typedef struct {
    int list_cyc, list_cnt, load_cyc, load_cnt, opa, opb, start_cyc, start_cnt, aop;
    int done_cyc, done_cnt, rm, rn, err_cyc, err_cnt, ecode, ready_cyc;
  } obs_t;
  typedef struct {int op, a, b, d, rm, rn, code, ecyc, em, en;} vec_t;

  int sm[10], sn[10];
  bit sv[10];
  int pass_cnt = 0, tot_cnt = 0;
  int last_m = 0, last_n = 0, last_code = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_table_slots();
    int tm[10] = '{2, 2, 2, 3, 2, 2, 4, 1, 1, 1};
    int tn[10] = '{3, 3, 3, 4, 5, 3, 4, 1, 1, 1};
    for (int k = 0; k < 10; k++) begin
      sm[k] = tm[k];
      sn[k] = tn[k];
      sv[k] = (k != 5);
    end
  endtask

  task automatic drive_slots();
    for (int k = 0; k < 10; k++) begin
      list_m_flat[3*k +: 3] = 3'(sm[k]);
      list_n_flat[3*k +: 3] = 3'(sn[k]);
      list_valid_flat[k]    = sv[k];
    end
  endtask

  // Outcome and timeline derived from the command rules: ids, dimensions, ALU delay.
  function automatic pred_t predict(int op, int a, int b, int d, int rm, int rn);
    pred_t p;
    bit a_bad, b_bad, need_b, dims;
    p = '{code: 0, ecyc: 3, em: 0, en: 0, loads: 0};
    need_b = (op == 0) || (op == 3);
    a_bad = (a > 9) ? 1'b1 : !sv[a];
    b_bad = (b > 9) ? 1'b1 : !sv[b];
    if (a_bad || (need_b && b_bad)) begin
      p.code = 1;
      return p;
    end
    dims = 1;
    if (op == 0) dims = (sm[a] == sm[b]) && (sn[a] == sn[b]);
    if (op == 3) dims = (sn[a] == sm[b]);
    if (!dims) begin
      p.code = 2;
      return p;
    end
    p.loads = 1;
    case (op)
      1: begin p.em = sn[a]; p.en = sm[a]; end
      3: begin p.em = sm[a]; p.en = sn[b]; end
      default: begin p.em = sm[a]; p.en = sn[a]; end
    endcase
    if (d > TO) begin
      p.code = 3;
      p.ecyc = 5 + TO + 1;
    end else begin
      p.ecyc = 5 + d + 1;
      if (rm != p.em || rn != p.en) p.code = 2;
    end
    return p;
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge where cmd_ready is back.
  task automatic run_txn(input int op, a, b, d, rm, rn, input bit stray, output obs_t o);
    o = '{default: -1};
    o.list_cnt = 0; o.load_cnt = 0; o.start_cnt = 0; o.done_cnt = 0; o.err_cnt = 0;
    drive_slots();
    alu_res_m = 3'(rm);
    alu_res_n = 3'(rn);
    cmd_valid = 1'b1;
    cmd_op = 2'(op);
    cmd_a_id = 4'(a);
    cmd_b_id = 4'(b);
    alu_done = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (req_list_info) begin o.list_cnt++; if (o.list_cyc < 0) o.list_cyc = k; end
      if (load_operands) begin
        o.load_cnt++; o.load_cyc = k; o.opa = operand_a_id; o.opb = operand_b_id;
      end
      if (alu_start) begin o.start_cnt++; o.start_cyc = k; o.aop = alu_op; end
      if (op_done) begin o.done_cnt++; o.done_cyc = k; o.rm = result_m; o.rn = result_n; end
      if (err_valid) begin o.err_cnt++; o.err_cyc = k; o.ecode = err_code; end
      if (cmd_ready) begin
        o.ready_cyc = k;
        cmd_valid = 1'b0;
        alu_done = 1'b0;
        break;
      end
      cmd_valid = 1'($urandom);
      cmd_op = 2'($urandom);
      cmd_a_id = 4'($urandom);
      cmd_b_id = 4'($urandom);
      alu_done = (k == 5 + d) || (stray && (k < 5 || k > 6 + d));
    end
  endtask

  task automatic check_obs(input string t, input int op, a, b, input pred_t p, input obs_t o);
    chk($sformatf("%s.list_cyc", t), o.list_cyc, 1);
    chk($sformatf("%s.list_cnt", t), o.list_cnt, 1);
    if (p.loads) begin
      chk($sformatf("%s.load_cyc", t), o.load_cyc, 3);
      chk($sformatf("%s.load_cnt", t), o.load_cnt, 1);
      chk($sformatf("%s.opa", t), o.opa, a);
      chk($sformatf("%s.opb", t), o.opb, (op == 1 || op == 2) ? a : b);
      chk($sformatf("%s.start_cyc", t), o.start_cyc, 4);
      chk($sformatf("%s.start_cnt", t), o.start_cnt, 1);
      chk($sformatf("%s.alu_op", t), o.aop, op);
    end else begin
      chk($sformatf("%s.no_load", t), o.load_cnt, 0);
      chk($sformatf("%s.no_start", t), o.start_cnt, 0);
    end
    if (p.code == 0) begin
      chk($sformatf("%s.done_cyc", t), o.done_cyc, p.ecyc);
      chk($sformatf("%s.done_cnt", t), o.done_cnt, 1);
      chk($sformatf("%s.res_m", t), o.rm, p.em);
      chk($sformatf("%s.res_n", t), o.rn, p.en);
      chk($sformatf("%s.no_err", t), o.err_cnt, 0);
      chk($sformatf("%s.ready_cyc", t), o.ready_cyc, p.ecyc + 1 + DR);
      last_m = p.em;
      last_n = p.en;
    end else begin
      chk($sformatf("%s.err_cyc", t), o.err_cyc, p.ecyc);
      chk($sformatf("%s.err_cnt", t), o.err_cnt, 1);
      chk($sformatf("%s.err_code", t), o.ecode, p.code);
      chk($sformatf("%s.no_done", t), o.done_cnt, 0);
      chk($sformatf("%s.ready_cyc", t), o.ready_cyc, p.ecyc + 1);
      last_code = p.code;
    end
    chk($sformatf("%s.hold_m", t), result_m, last_m);
    chk($sformatf("%s.hold_n", t), result_n, last_n);
    chk($sformatf("%s.hold_code", t), err_code, last_code);
  endtask

  task automatic chk_reset_outs(input string t);
    chk($sformatf("%s.outs_zero", t),
        {req_list_info, load_operands, operand_a_id, operand_b_id, alu_start, alu_op,
         op_done, result_m, result_n, busy, err_valid, err_code}, 0);
    chk($sformatf("%s.cmd_ready", t), cmd_ready, 1);
  endtask

  // Reset asserted at cycle rst_cyc of an add(0,1); late alu_done afterwards must be ignored.
  task automatic reset_abort(input string t, input int d, input int rst_cyc);
    int dn = 0, en = 0;
    set_table_slots();
    drive_slots();
    alu_res_m = 3'd2;
    alu_res_n = 3'd3;
    cmd_op = 2'd0; cmd_a_id = 4'd0; cmd_b_id = 4'd1;
    cmd_valid = 1'b1;
    for (int k = 1; k <= rst_cyc; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      alu_done = (k == 5 + d);
    end
    chk($sformatf("%s.busy_before", t), busy, 1);
    rst_n = 1'b0;
    alu_done = 1'b0;
    #1;
    chk_reset_outs($sformatf("%s.async", t));
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 0; last_n = 0; last_code = 0;
    for (int k = 1; k <= 15; k++) begin
      alu_done = (k <= 3);
      @(negedge clk);
      if (op_done) dn++;
      if (err_valid) en++;
    end
    alu_done = 1'b0;
    chk($sformatf("%s.no_done_after", t), dn, 0);
    chk($sformatf("%s.no_err_after", t), en, 0);
    chk($sformatf("%s.idle_after", t), cmd_ready, 1);
  endtask

  initial begin
    vec_t  tbl[15];
    pred_t p;
    obs_t  o;
    // op: 0 add, 1 transpose, 2 scalar, 3 multiply; d = alu_done delay after WAIT entry
    tbl[0]  = '{0, 0, 1,  3, 2, 3, 0,  9, 2, 3};
    tbl[1]  = '{3, 2, 3,  2, 2, 4, 0,  8, 2, 4};
    tbl[2]  = '{3, 2, 6,  2, 2, 4, 2,  3, 0, 0};
    tbl[3]  = '{0, 0, 12, 2, 2, 3, 1,  3, 0, 0};
    tbl[4]  = '{0, 0, 5,  2, 2, 3, 1,  3, 0, 0};
    tbl[5]  = '{0, 0, 1, 99, 2, 3, 3, 16, 0, 0};
    tbl[6]  = '{0, 0, 1, 10, 2, 3, 0, 16, 2, 3};
    tbl[7]  = '{1, 4, 7,  0, 5, 2, 0,  6, 5, 2};
    tbl[8]  = '{1, 4, 7,  0, 2, 5, 2,  6, 0, 0};
    tbl[9]  = '{2, 3, 9,  1, 3, 4, 0,  7, 3, 4};
    tbl[10] = '{0, 0, 1, 11, 2, 3, 3, 16, 0, 0};
    tbl[11] = '{3, 3, 2,  2, 2, 3, 2,  3, 0, 0};
    tbl[12] = '{1, 4, 13, 0, 5, 2, 0,  6, 5, 2};
    tbl[13] = '{2, 5, 0,  0, 2, 3, 1,  3, 0, 0};
    tbl[14] = '{0, 9, 10, 0, 1, 1, 1,  3, 0, 0};

    @(negedge clk);
    chk_reset_outs("reset0");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_table_slots();
    for (int i = 0; i < 15; i++) begin
      p.code  = tbl[i].code;
      p.ecyc  = tbl[i].ecyc;
      p.em    = tbl[i].em;
      p.en    = tbl[i].en;
      p.loads = !(tbl[i].code != 0 && tbl[i].ecyc == 3);
      run_txn(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].rm, tbl[i].rn, 1'(i), o);
      check_obs($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, p, o);
    end

    reset_abort("rst_wait", 99, 9);
    reset_abort("rst_drain", 1, 10);

    for (int i = 0; i < 40; i++) begin
      int op, a, b, d, rm, rn;
      for (int k = 0; k < 10; k++) begin
        sm[k] = $urandom_range(1, 3);
        sn[k] = $urandom_range(1, 3);
        sv[k] = ($urandom_range(0, 7) != 0);
      end
      op = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      b = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      d = $urandom_range(0, 12);
      p = predict(op, a, b, d, 0, 0);
      rm = p.em;
      rn = p.en;
      if ($urandom_range(0, 3) == 0) begin
        rm = $urandom_range(0, 7);
        rn = $urandom_range(0, 7);
      end
      p = predict(op, a, b, d, rm, rn);
      run_txn(op, a, b, d, rm, rn, 1'($urandom), o);
      check_obs($sformatf("rnd%0d", i), op, a, b, p, o);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
